// File: rtl/nios_system_quad_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : nios_system_quad_encoder_if
// Description : Avalon-MM slave bus bundle for the quadrature encoder counter.
//               Zero-wait-state, PIO-style signalling: address/chipselect/
//               write_n/writedata in, readdata out.
//   slave  modport : seen by the encoder counter
//   master modport : seen by the bus master (Nios II interconnect / bench)
// Revision    : 1.0 - initial release
// ============================================================================
interface nios_system_quad_encoder_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );
endinterface
`default_nettype wire

// File: rtl/nios_system_quad_encoder.sv
`default_nettype none
// ============================================================================
// Module      : nios_system_quad_encoder
// Description : Quadrature encoder counter. Synchronizes and glitch-filters
//               the raw A/B pins, decodes x4 quadrature into a signed 32-bit
//               wrapping position, and measures velocity over a fixed window.
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   enc_a/b    : raw encoder channels, asynchronous to clk
//   enc_clear  : level from encoder-reset PIO; holds count/velocity/window at 0
//   avs        : Avalon-MM slave (0 count, 1 velocity, 2 status, 3 control)
//   dir        : direction of last applied step (1 = forward)
//   irq        : err_flag AND irq_en
// Revision    : 1.0 - initial release
// ============================================================================
module nios_system_quad_encoder #(
    parameter int FILTER_LEN = 4,
    parameter int PERIOD     = 50000
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    input  wire logic                  enc_a,
    input  wire logic                  enc_b,
    input  wire logic                  enc_clear,
    nios_system_quad_encoder_if.slave  avs,
    output logic                       dir,
    output logic                       irq
);

    localparam int                WIN_W      = $clog2(PERIOD);
    localparam logic [7:0]        C_FILT_LAST = 8'(FILTER_LEN - 1);
    localparam logic [WIN_W-1:0]  C_WIN_LAST  = WIN_W'(PERIOD - 1);

    logic [1:0] w_raw;     // [1] = A, [0] = B
    logic [1:0] w_filt;

    assign w_raw = {enc_a, enc_b};

    // Per-channel synchronizer + persistence filter. The filtered level only
    // follows the synchronized level after FILTER_LEN consecutive mismatches.
    generate
        for (genvar i = 0; i < 2; i++) begin : g_chan
            logic       r_sync1;
            logic       r_sync2;
            logic       r_level;
            logic [7:0] r_cnt;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_level <= 1'b0;
                    r_cnt   <= 8'd0;
                end else begin
                    r_sync1 <= w_raw[i];
                    r_sync2 <= r_sync1;
                    if (r_sync2 == r_level) begin
                        r_cnt <= 8'd0;
                    end else if (r_cnt == C_FILT_LAST) begin
                        r_level <= r_sync2;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
            end

            assign w_filt[i] = r_level;
        end
    endgenerate

    // Quadrature decode. Mapping {B, A^B} turns the gray sequence
    // 00->10->11->01 into phase 0,1,2,3 so the step is a 2-bit difference.
    logic [1:0] r_prev_ab;
    logic [1:0] w_ph_new;
    logic [1:0] w_ph_old;
    logic [1:0] w_delta;
    logic       w_fwd;
    logic       w_rev;
    logic       w_illegal;

    assign w_ph_new  = {w_filt[0], w_filt[1] ^ w_filt[0]};
    assign w_ph_old  = {r_prev_ab[0], r_prev_ab[1] ^ r_prev_ab[0]};
    assign w_delta   = w_ph_new - w_ph_old;
    assign w_fwd     = (w_delta == 2'd1);
    assign w_rev     = (w_delta == 2'd3);
    assign w_illegal = (w_delta == 2'd2);

    // Control / status registers
    logic        r_enable;
    logic        r_invert;
    logic        r_irq_en;
    logic        r_err_flag;
    logic [7:0]  r_err_cnt;
    logic [31:0] r_count;
    logic [31:0] r_snap;
    logic [31:0] r_velocity;
    logic [WIN_W-1:0] r_win;

    logic w_wr;
    logic w_err_clr;
    logic w_step;
    logic w_up;
    logic w_unused_wdata;

    assign w_wr      = avs.chipselect & ~avs.write_n;
    assign w_err_clr = w_wr & (avs.address == 2'd2) & avs.writedata[1];
    assign w_step    = r_enable & (w_fwd | w_rev);
    assign w_up      = w_fwd ^ r_invert;
    assign w_unused_wdata = ^avs.writedata[31:3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_ab <= 2'b00;
            r_enable  <= 1'b1;
            r_invert  <= 1'b0;
            r_irq_en  <= 1'b0;
        end else begin
            r_prev_ab <= w_filt;
            if (w_wr && avs.address == 2'd3) begin
                r_enable <= avs.writedata[0];
                r_invert <= avs.writedata[1];
                r_irq_en <= avs.writedata[2];
            end
        end
    end

    // A new illegal transition wins over a clearing write: the clear wipes
    // the old history and the new event is counted on top of it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_flag <= 1'b0;
            r_err_cnt  <= 8'd0;
        end else if (w_illegal) begin
            r_err_flag <= 1'b1;
            if (w_err_clr) begin
                r_err_cnt <= 8'd1;
            end else if (r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end else if (w_err_clr) begin
            r_err_flag <= 1'b0;
            r_err_cnt  <= 8'd0;
        end
    end

    // Position, direction and velocity window; enc_clear overrides steps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= 32'd0;
            r_snap     <= 32'd0;
            r_velocity <= 32'd0;
            r_win      <= '0;
            dir        <= 1'b0;
        end else if (enc_clear) begin
            r_count    <= 32'd0;
            r_snap     <= 32'd0;
            r_velocity <= 32'd0;
            r_win      <= '0;
        end else begin
            if (w_step) begin
                r_count <= w_up ? (r_count + 32'd1) : (r_count - 32'd1);
                dir     <= w_up;
            end
            if (r_win == C_WIN_LAST) begin
                r_win      <= '0;
                r_velocity <= r_count - r_snap;
                r_snap     <= r_count;
            end else begin
                r_win <= r_win + 1'b1;
            end
        end
    end

    assign irq = r_err_flag & r_irq_en;

    always_comb begin
        avs.readdata = 32'd0;
        case (avs.address)
            2'd0:    avs.readdata = r_count;
            2'd1:    avs.readdata = r_velocity;
            2'd2:    avs.readdata = {16'd0, r_err_cnt, 6'd0, r_err_flag, dir};
            default: avs.readdata = {29'd0, r_irq_en, r_invert, r_enable};
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_nios_system_quad_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_nios_system_quad_encoder
// Description : Directed self-checking bench for nios_system_quad_encoder
//               (FILTER_LEN = 4, PERIOD = 1000).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nios_system_quad_encoder;

    localparam int FILTER_LEN = 4;
    localparam int PERIOD     = 1000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enc_a = 1'b0;
    logic enc_b = 1'b0;
    logic enc_clear = 1'b0;
    logic dir;
    logic irq;

    int cmp_cnt  = 0;
    int fail_cnt = 0;
    int idx      = 0;   // bench's own quadrature phase: 0=00,1=10,2=11,3=01

    nios_system_quad_encoder_if avs_bus ();

    nios_system_quad_encoder #(
        .FILTER_LEN (FILTER_LEN),
        .PERIOD     (PERIOD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .enc_clear (enc_clear),
        .avs       (avs_bus),
        .dir       (dir),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_phase();
        case (idx)
            0: begin enc_a = 1'b0; enc_b = 1'b0; end
            1: begin enc_a = 1'b1; enc_b = 1'b0; end
            2: begin enc_a = 1'b1; enc_b = 1'b1; end
            default: begin enc_a = 1'b0; enc_b = 1'b1; end
        endcase
    endtask

    task automatic fwd(input int n, input int gap);
        repeat (n) begin
            idx = (idx + 1) % 4;
            drive_phase();
            step_clk(gap);
        end
    endtask

    task automatic rev(input int n, input int gap);
        repeat (n) begin
            idx = (idx + 3) % 4;
            drive_phase();
            step_clk(gap);
        end
    endtask

    task automatic rd(input logic [1:0] addr, output logic [31:0] data);
        avs_bus.address = addr;
        #1;
        data = avs_bus.readdata;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        avs_bus.address    = addr;
        avs_bus.writedata  = data;
        avs_bus.chipselect = 1'b1;
        avs_bus.write_n    = 1'b0;
        step_clk(1);
        avs_bus.chipselect = 1'b0;
        avs_bus.write_n    = 1'b1;
    endtask

    task automatic do_reset();
        idx = 0;
        drive_phase();
        enc_clear = 1'b0;
        reset_n   = 1'b0;
        step_clk(3);
        reset_n   = 1'b1;
        step_clk(2);
    endtask

    logic [31:0] d;

    initial begin
        avs_bus.address    = 2'd0;
        avs_bus.chipselect = 1'b0;
        avs_bus.write_n    = 1'b1;
        avs_bus.writedata  = 32'd0;
        do_reset();

        // Reset state
        rd(2'd0, d); chk("rst_count", d, 32'h0);
        rd(2'd1, d); chk("rst_velocity", d, 32'h0);
        rd(2'd2, d); chk("rst_status", d, 32'h0);
        rd(2'd3, d); chk("rst_control", d, 32'h1);
        chk("rst_dir_irq", {30'd0, dir, irq}, 32'h0);

        // Forward 32 edges then reverse 40 edges
        fwd(32, 10);
        rd(2'd0, d); chk("fwd32_count", d, 32'd32);
        chk("fwd32_dir", {31'd0, dir}, 32'd1);
        rev(40, 10);
        rd(2'd0, d); chk("rev40_count", d, 32'hFFFF_FFF8);
        chk("rev40_dir", {31'd0, dir}, 32'd0);

        // Glitch rejection and exact latency
        do_reset();
        enc_a = 1'b1;
        step_clk(3);
        enc_a = 1'b0;
        step_clk(15);
        rd(2'd0, d); chk("glitch_count", d, 32'd0);
        idx = 1;
        drive_phase();
        step_clk(6);
        rd(2'd0, d); chk("latency_early", d, 32'd0);
        step_clk(1);
        rd(2'd0, d); chk("latency_edge", d, 32'd1);

        // Illegal transition, irq, error clear
        do_reset();
        wr(2'd3, 32'h5);
        idx = 2;
        drive_phase();
        step_clk(10);
        rd(2'd0, d); chk("illegal_count", d, 32'd0);
        rd(2'd2, d); chk("illegal_status", d, 32'h0000_0102);
        chk("illegal_irq", {31'd0, irq}, 32'd1);
        wr(2'd2, 32'h2);
        rd(2'd2, d); chk("errclr_status", d & 32'h0000_FFFE, 32'h0);
        chk("errclr_irq", {31'd0, irq}, 32'd0);

        // Writes to read-only addresses are ignored
        wr(2'd0, 32'h1234_5678);
        rd(2'd0, d); chk("ro_count", d, 32'd0);

        // Velocity: 1 step per 100 clk, window 1000
        do_reset();
        fwd(25, 100);
        rd(2'd1, d); chk("velocity", d, 32'd10);
        rd(2'd0, d); chk("vel_count", d, 32'd25);

        // enc_clear with a step landing on the first cleared edge
        idx = (idx + 1) % 4;
        drive_phase();
        step_clk(6);
        enc_clear = 1'b1;
        step_clk(5);
        rd(2'd0, d); chk("clear_count", d, 32'd0);
        rd(2'd1, d); chk("clear_velocity", d, 32'd0);
        enc_clear = 1'b0;
        step_clk(20);
        rd(2'd0, d); chk("clear_hold", d, 32'd0);
        fwd(1, 10);
        rd(2'd0, d); chk("clear_resume", d, 32'd1);

        // Invert makes forward decrement (wraps through zero), enable freezes
        wr(2'd3, 32'h3);
        fwd(2, 10);
        rd(2'd0, d); chk("invert_count", d, 32'hFFFF_FFFF);
        wr(2'd3, 32'h0);
        rd(2'd3, d); chk("ctrl_readback", d, 32'h0);
        fwd(3, 10);
        rd(2'd0, d); chk("disable_count", d, 32'hFFFF_FFFF);

        // Asynchronous reset mid-cycle
        #3;
        reset_n = 1'b0;
        #1;
        rd(2'd0, d); chk("async_rst_count", d, 32'h0);
        rd(2'd3, d); chk("async_rst_ctrl", d, 32'h1);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
`default_nettype wire
